// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-side slave responders and the
// Raddr/Rdata interconnect.
//   - Width constants for IDs, addresses, lengths, sizes and data.
//   - Burst and response encodings.
//   - Read-responder FSM state type.
//   - A helper that clamps the beat size to the data-bus width.
package axi_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_DATA_BITS = 32;
    localparam int MEM_ADDR_BITS = 14;

    // Byte-address window covered by the SRAM (word address plus 2 lane bits).
    localparam int WIN_ADDR_BITS = MEM_ADDR_BITS + 2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Beat sizes wider than the 32-bit bus are served as full words.
    localparam logic [AXI_SIZE_BITS-1:0] SIZE_MAX = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } rd_state_e;

    // Limit a requested beat size to the widest size the bus supports.
    function automatic logic [AXI_SIZE_BITS-1:0] clamp_size(
        input logic [AXI_SIZE_BITS-1:0] size
    );
        logic [AXI_SIZE_BITS-1:0] result;
        if (size > SIZE_MAX) begin
            result = SIZE_MAX;
        end else begin
            result = size;
        end
        return result;
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Next-beat address generator for AXI bursts within the SRAM window.
//   addr      in   current byte address (window bits only)
//   size      in   log2 bytes per beat (already clamped)
//   burst     in   burst type; FIXED holds the address, anything else increments
//   next_addr out  address of the following beat, wrapping within the window
import axi_pkg::*;

module burst_addr_gen (
    input  logic [WIN_ADDR_BITS-1:0] addr,
    input  logic [AXI_SIZE_BITS-1:0] size,
    input  logic [1:0]               burst,
    output logic [WIN_ADDR_BITS-1:0] next_addr
);

    // Select hold or increment; the window-width add wraps naturally.
    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            default:     next_addr = addr + (16'd1 << size);
        endcase
    end

endmodule

// File: rtl/sram_rd_slave.sv
// AXI read-channel responder serving bursts from a single-port synchronous SRAM.
// One AR transaction is accepted at a time; each beat issues one SRAM read
// (FETCH) followed by one R beat (DATA).
//   clk, rst              clock and asynchronous active-high reset
//   ARID..ARValid/ARReady read-address channel
//   RID..RValid/RReady    read-data channel (RResp always OKAY)
//   mem_cs, mem_addr      SRAM read strobe and word address
//   mem_rdata             SRAM output, valid the cycle after mem_cs and held
import axi_pkg::*;

module sram_rd_slave (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  ARID,
    input  logic [AXI_ADDR_BITS-1:0] ARAddr,
    input  logic [AXI_LEN_BITS-1:0]  ARLen,
    input  logic [AXI_SIZE_BITS-1:0] ARSize,
    input  logic [1:0]               ARBurst,
    input  logic                     ARValid,
    output logic                     ARReady,
    output logic [AXI_IDS_BITS-1:0]  RID,
    output logic [AXI_DATA_BITS-1:0] RData,
    output logic [1:0]               RResp,
    output logic                     RLast,
    output logic                     RValid,
    input  logic                     RReady,
    output logic                     mem_cs,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    input  logic [AXI_DATA_BITS-1:0] mem_rdata
);

    rd_state_e                state_r;
    rd_state_e                next_state_s;
    logic [AXI_IDS_BITS-1:0]  id_r;
    logic [WIN_ADDR_BITS-1:0] addr_r;
    logic [AXI_LEN_BITS-1:0]  len_r;
    logic [AXI_LEN_BITS-1:0]  cnt_r;
    logic [AXI_SIZE_BITS-1:0] size_r;
    logic [1:0]               burst_r;
    logic [WIN_ADDR_BITS-1:0] next_addr_s;
    logic                     last_s;
    logic                     ar_hs_s;
    logic                     r_hs_s;

    // Address bits above the SRAM window never reach the memory.
    logic                     unused_addr_s;
    assign unused_addr_s = ^ARAddr[AXI_ADDR_BITS-1:WIN_ADDR_BITS];

    assign last_s  = (cnt_r == len_r);
    assign ar_hs_s = ARValid && (state_r == IDLE);
    assign r_hs_s  = RReady && (state_r == DATA);

    burst_addr_gen u_addr_gen (
        .addr      (addr_r),
        .size      (size_r),
        .burst     (burst_r),
        .next_addr (next_addr_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (ARValid) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: next_state_s = DATA;
            DATA: begin
                if (RReady && last_s) begin
                    next_state_s = IDLE;
                end else if (RReady) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = DATA;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Transaction context: latched on AR handshake, advanced on each non-final R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r    <= 8'd0;
            addr_r  <= 16'd0;
            len_r   <= 4'd0;
            cnt_r   <= 4'd0;
            size_r  <= 3'd0;
            burst_r <= 2'b00;
        end else if (ar_hs_s) begin
            id_r    <= ARID;
            addr_r  <= ARAddr[WIN_ADDR_BITS-1:0];
            len_r   <= ARLen;
            cnt_r   <= 4'd0;
            size_r  <= clamp_size(ARSize);
            burst_r <= ARBurst;
        end else if (r_hs_s && !last_s) begin
            cnt_r   <= cnt_r + 4'd1;
            addr_r  <= next_addr_s;
        end
    end

    // Outputs are decoded from registered state only; RData passes the SRAM
    // output straight through because the SRAM holds it while mem_cs is low.
    always_comb begin
        ARReady  = (state_r == IDLE);
        mem_cs   = (state_r == FETCH);
        RValid   = (state_r == DATA);
        RLast    = (state_r == DATA) && last_s;
        RID      = id_r;
        RResp    = RESP_OKAY;
        RData    = mem_rdata;
        mem_addr = addr_r[WIN_ADDR_BITS-1:2];
    end

endmodule

// File: tb/tb_sram_rd_slave.sv
// Directed self-checking bench for sram_rd_slave.
import axi_pkg::*;

module tb_sram_rd_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ARID;
    logic [31:0] ARAddr;
    logic [3:0]  ARLen;
    logic [2:0]  ARSize;
    logic [1:0]  ARBurst;
    logic        ARValid;
    logic        ARReady;
    logic [7:0]  RID;
    logic [31:0] RData;
    logic [1:0]  RResp;
    logic        RLast;
    logic        RValid;
    logic        RReady;
    logic        mem_cs;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    sram_rd_slave dut (
        .clk       (clk),
        .rst       (rst),
        .ARID      (ARID),
        .ARAddr    (ARAddr),
        .ARLen     (ARLen),
        .ARSize    (ARSize),
        .ARBurst   (ARBurst),
        .ARValid   (ARValid),
        .ARReady   (ARReady),
        .RID       (RID),
        .RData     (RData),
        .RResp     (RResp),
        .RLast     (RLast),
        .RValid    (RValid),
        .RReady    (RReady),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: contents are a fixed tag plus the word address.
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    always @(posedge clk) begin
        if (mem_cs) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an AR request, wait (bounded) for ARReady, handshake at the next edge.
    task automatic start_ar(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int waited = 0;
        ARID = id; ARAddr = addr; ARLen = len; ARSize = size; ARBurst = burst;
        ARValid = 1'b1;
        while (!ARReady && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) chk("ar_timeout", 32'd1, 32'd0);
        tick();
        ARValid = 1'b0;
    endtask

    // Check a burst with RReady held high; call right after start_ar.
    task automatic run_burst(input string tag, input logic [7:0] id,
                             input logic [15:0] start, input int beats,
                             input logic fixed);
        logic [15:0] ea;
        ea = start;
        RReady = 1'b1;
        for (int k = 0; k < beats; k++) begin
            chk({tag, "_cs"}, {31'd0, mem_cs}, 32'd1);
            chk({tag, "_maddr"}, {18'd0, mem_addr}, {18'd0, ea[15:2]});
            chk({tag, "_arrdy_busy"}, {31'd0, ARReady}, 32'd0);
            tick();
            chk({tag, "_rvalid"}, {31'd0, RValid}, 32'd1);
            chk({tag, "_rid"}, {24'd0, RID}, {24'd0, id});
            chk({tag, "_rdata"}, RData, mem_word(ea[15:2]));
            chk({tag, "_rlast"}, {31'd0, RLast}, (k == beats - 1) ? 32'd1 : 32'd0);
            chk({tag, "_rresp"}, {30'd0, RResp}, 32'd0);
            tick();
            if (!fixed) ea = ea + 16'd4;
        end
        chk({tag, "_arrdy_end"}, {31'd0, ARReady}, 32'd1);
        chk({tag, "_rvalid_end"}, {31'd0, RValid}, 32'd0);
    endtask

    logic [31:0] held_data;

    initial begin
        rst = 1'b1; ARValid = 1'b0; RReady = 1'b0;
        ARID = 8'd0; ARAddr = 32'd0; ARLen = 4'd0; ARSize = 3'd0; ARBurst = 2'b00;
        tick(); tick();
        chk("rst_arready", {31'd0, ARReady}, 32'd1);
        chk("rst_rvalid", {31'd0, RValid}, 32'd0);
        chk("rst_rlast", {31'd0, RLast}, 32'd0);
        chk("rst_rid", {24'd0, RID}, 32'd0);
        chk("rst_memcs", {31'd0, mem_cs}, 32'd0);
        chk("rst_maddr", {18'd0, mem_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // Single beat
        start_ar(8'h13, 32'h0000_0010, 4'd0, 3'd2, BURST_INCR);
        run_burst("single", 8'h13, 16'h0010, 1, 1'b0);

        // INCR burst of 4
        start_ar(8'h21, 32'h0000_0100, 4'd3, 3'd2, BURST_INCR);
        run_burst("incr", 8'h21, 16'h0100, 4, 1'b0);

        // FIXED burst of 3
        start_ar(8'h31, 32'h0000_0020, 4'd2, 3'd2, BURST_FIXED);
        run_burst("fixed", 8'h31, 16'h0020, 3, 1'b1);

        // Oversize request clamped to word stride
        start_ar(8'h41, 32'h0000_0400, 4'd1, 3'd3, BURST_INCR);
        run_burst("clamp", 8'h41, 16'h0400, 2, 1'b0);

        // Wrap at the top of the window; burst type 11 behaves as INCR
        start_ar(8'h51, 32'h0000_FFFC, 4'd1, 3'd2, 2'b11);
        run_burst("wrap", 8'h51, 16'hFFFC, 2, 1'b0);

        // Backpressure on beat 1 of a 2-beat burst
        RReady = 1'b0;
        start_ar(8'h61, 32'h0000_0200, 4'd1, 3'd2, BURST_INCR);
        chk("bp_maddr0", {18'd0, mem_addr}, 32'h80);
        tick();
        held_data = mem_word(14'h0080);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid", {31'd0, RValid}, 32'd1);
            chk("bp_rdata", RData, held_data);
            chk("bp_rid", {24'd0, RID}, 32'h61);
            chk("bp_memcs", {31'd0, mem_cs}, 32'd0);
            chk("bp_rlast", {31'd0, RLast}, 32'd0);
            tick();
        end
        RReady = 1'b1;
        tick();
        chk("bp_fetch_cs", {31'd0, mem_cs}, 32'd1);
        chk("bp_fetch_addr", {18'd0, mem_addr}, 32'h81);
        tick();
        chk("bp_b2_rdata", RData, mem_word(14'h0081));
        chk("bp_b2_rlast", {31'd0, RLast}, 32'd1);
        tick();
        chk("bp_idle", {31'd0, ARReady}, 32'd1);

        // Reset during beat 2 of an 8-beat burst
        start_ar(8'h5A, 32'h0000_0300, 4'd7, 3'd2, BURST_INCR);
        tick();
        chk("mid_b1_rvalid", {31'd0, RValid}, 32'd1);
        tick();
        chk("mid_b2_cs", {31'd0, mem_cs}, 32'd1);
        tick();
        chk("mid_b2_rvalid", {31'd0, RValid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", {31'd0, RValid}, 32'd0);
        chk("mid_rst_arready", {31'd0, ARReady}, 32'd1);
        chk("mid_rst_rid", {24'd0, RID}, 32'd0);
        chk("mid_rst_memcs", {31'd0, mem_cs}, 32'd0);
        chk("mid_rst_maddr", {18'd0, mem_addr}, 32'd0);
        chk("mid_rst_rlast", {31'd0, RLast}, 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_quiet", {31'd0, RValid}, 32'd0);
        start_ar(8'h22, 32'h0000_0040, 4'd1, 3'd2, BURST_INCR);
        run_burst("post_rst", 8'h22, 16'h0040, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_rd_slave.md
# sram_rd_slave

AXI read-channel responder that sits behind the read-address interconnect at a slave port (S0/S1) and serves bursts from a single-port synchronous SRAM. It accepts one AR transaction at a time, issues one SRAM read per beat, and returns R beats in order with the interconnect-extended ID. RLAST is asserted on the final beat.

## Interface
- AXI_IDS_BITS, 8: slave-side ID width (master ID plus master-select tag).
- AXI_ADDR_BITS, 32: byte address width.
- AXI_LEN_BITS, 4: burst length field width; number of beats is LEN+1.
- AXI_SIZE_BITS, 3: beat size field width.
- AXI_DATA_BITS, 32: data width.
- MEM_ADDR_BITS, 14: SRAM word address width, giving a 64 KiB window.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ARID  in  AXI_IDS_BITS  request ID.
- ARAddr  in  AXI_ADDR_BITS  start byte address.
- ARLen  in  AXI_LEN_BITS  beats minus one.
- ARSize  in  AXI_SIZE_BITS  log2 bytes per beat.
- ARBurst  in  2  00 FIXED, 01 INCR; 10 and 11 are treated as INCR.
- ARValid  in  1  request valid.
- ARReady  out  1  request accepted.
- RID  out  AXI_IDS_BITS  echoed ARID.
- RData  out  AXI_DATA_BITS  read data.
- RResp  out  2  always 2'b00 (OKAY).
- RLast  out  1  final beat.
- RValid  out  1  beat valid.
- RReady  in  1  master accepts beat.
- mem_cs  out  1  SRAM read strobe, active-high.
- mem_addr  out  MEM_ADDR_BITS  SRAM word address, equal to addr[MEM_ADDR_BITS+1:2].
- mem_rdata  in  AXI_DATA_BITS  SRAM output. Valid the cycle after mem_cs, and held until the next mem_cs.

## Operation
- FSM states and outputs:
  - IDLE: ARReady=1.
  - FETCH: mem_cs=1.
  - DATA: RValid=1, RData=mem_rdata.
- IDLE→FETCH on ARValid&&ARReady. The following are latched on that handshake:
  - ID, addr, len, burst.
  - size, clamped to 2 when ARSize>2.
  - Beat counter cnt is cleared to 0.
- FETCH→DATA unconditionally after one cycle.
- DATA holds while !RReady. RValid, RData, RID and RLast stay stable throughout the hold, and no mem_cs is issued.
- On an R handshake in DATA:
  - If RLast: go to IDLE.
  - Otherwise: cnt+1, update addr, go to FETCH.
- Address update:
  - INCR: addr += (1<<size). Only addr[15:0] is kept; overflow wraps modulo 64 KiB.
  - FIXED: addr is unchanged.
- RLast = (cnt == len). cnt is AXI_LEN_BITS wide and never exceeds len.
- Sub-word sizes return the full word. Byte-lane selection is the master's responsibility.
- ARValid arriving outside IDLE is ignored (ARReady=0) until the state returns to IDLE. Requests are never dropped, because the master holds ARValid.

## Timing
- Reset values: state IDLE, ARReady=1, RValid=0, RLast=0, RID=0, RResp=0, mem_cs=0, mem_addr=0. Registered addr, len, cnt and id are all 0.
- rst asserted mid-burst aborts the burst immediately (asynchronous). No further R beats are produced for that burst.
- Latency, with the AR handshake at edge 0:
  - FETCH in cycle 1.
  - First RValid in cycle 2.
  - With RReady held high, one beat every 2 cycles.
  - With RReady=1 and a pending ARValid, the next ARReady is in the cycle after the last beat's handshake.
- RData is the combinational pass-through of mem_rdata, which the SRAM holds stable while mem_cs=0.
- All outputs except RData depend only on registered state.

## Structure
- Shared package axi_pkg holds:
  - Width constants.
  - Burst encodings BURST_FIXED/BURST_INCR.
  - RESP_OKAY.
  - typedef enum logic [1:0] {IDLE, FETCH, DATA} rd_state_e.
- The Raddr/Rdata interconnect uses the same package.
- One natural sub-module: burst_addr_gen. It computes the next address from addr, size and burst, and is reused by the future write-side responder.

## Test plan
- Single beat: ARAddr=0x0000_0010, Len=0, Size=2, INCR, ID=0x13, RReady=1.
  - mem_addr=4 in cycle 1.
  - RValid in cycle 2 with RID=0x13, RLast=1, RResp=0.
  - ARReady=1 in cycle 3.
- INCR burst: Addr=0x0000_0100, Len=3.
  - mem_addr sequence 0x40, 0x41, 0x42, 0x43.
  - 4 beats; RLast only on the 4th.
- FIXED burst: Addr=0x0000_0020, Len=2. mem_addr=8 on all 3 fetches.
- Backpressure: RReady=0 for 5 cycles on beat 1 of a Len=1 burst.
  - RValid, RData and RID stay stable.
  - mem_cs stays 0.
  - After RReady, the next fetch occurs.
- Wrap: Addr=0x0000_FFFC, Len=1, INCR.
  - mem_addr sequence 0x3FFF then 0x0000.
- Reset mid-burst: rst pulsed during beat 2 of a Len=7 burst.
  - Outputs return to reset values in the same cycle.
  - A new AR afterward completes normally with cnt restarting at 0.
